// File: rtl/exc_ctrl_if.sv
// Exception-controller bus: MEM-stage flags, CP0 state with WB bypass,
// and the outputs toward CP0 and the pipeline flush/redirect logic.
interface exc_ctrl_if;
  logic [31:0] mem_excepttype_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_is_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_reg_we_i;
  logic [4:0]  wb_cp0_reg_waddr_i;
  logic [31:0] wb_cp0_reg_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  // Pipeline side: drives the MEM/CP0/WB inputs, observes the results.
  modport master (
    output mem_excepttype_i, mem_inst_addr_i, mem_is_in_delayslot_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_reg_we_i, wb_cp0_reg_waddr_i, wb_cp0_reg_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
           flush_o, new_pc_o, busy_o
  );

  // Exception controller side.
  modport slave (
    input  mem_excepttype_i, mem_inst_addr_i, mem_is_in_delayslot_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_reg_we_i, wb_cp0_reg_waddr_i, wb_cp0_reg_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
           flush_o, new_pc_o, busy_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception arbiter. Merges raw exception flags with
// pending interrupts (CP0 state bypassed from WB), picks one exception code,
// raises flush + redirect PC, then holds flush for FLUSH_CYCLES in total.
// Optional macro EXC_STATS_EN adds exc_count_o (non-eret exceptions taken).
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  exc_ctrl_if.slave    bus
`ifdef EXC_STATS_EN
  ,
  output logic [31:0]  exc_count_o
`endif
);

  localparam logic [31:0] CODE_INT  = 32'h1;
  localparam logic [31:0] CODE_SYS  = 32'h8;
  localparam logic [31:0] CODE_INV  = 32'ha;
  localparam logic [31:0] CODE_TRAP = 32'hd;
  localparam logic [31:0] CODE_OV   = 32'hc;
  localparam logic [31:0] CODE_ERET = 32'he;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] pc_lat, pc_lat_n;

  logic [31:0] status, cause, epc;
  logic        int_pend;
  logic [31:0] sel;

  logic [31:0] exc_type, inst_addr, new_pc;
  logic        in_ds, flush, busy;

  // WB-stage CP0 writes are forwarded so this cycle sees the newest state.
  always_comb begin
    status = bus.cp0_status_i;
    epc    = bus.cp0_epc_i;
    cause  = bus.cp0_cause_i;
    if (bus.wb_cp0_reg_we_i && bus.wb_cp0_reg_waddr_i == 5'd12) status = bus.wb_cp0_reg_data_i;
    if (bus.wb_cp0_reg_we_i && bus.wb_cp0_reg_waddr_i == 5'd14) epc = bus.wb_cp0_reg_data_i;
    // Only the software-interrupt bits of Cause are writable.
    if (bus.wb_cp0_reg_we_i && bus.wb_cp0_reg_waddr_i == 5'd13) cause[9:8] = bus.wb_cp0_reg_data_i[9:8];
  end

  assign int_pend = ((cause[15:8] & status[15:8]) != 8'h0) && status[0] && !status[1];

  // Priority select; a bubble (PC 0) never raises anything.
  always_comb begin
    sel = 32'h0;
    if (bus.mem_inst_addr_i != 32'h0) begin
      if      (int_pend)                  sel = CODE_INT;
      else if (bus.mem_excepttype_i[8])   sel = CODE_SYS;
      else if (bus.mem_excepttype_i[9])   sel = CODE_INV;
      else if (bus.mem_excepttype_i[10])  sel = CODE_TRAP;
      else if (bus.mem_excepttype_i[11])  sel = CODE_OV;
      else if (bus.mem_excepttype_i[12])  sel = CODE_ERET;
    end
  end

  // State, flush counter and the redirect PC captured at detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      pc_lat <= 32'h0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pc_lat <= pc_lat_n;
    end
  end

  // Next state and outputs; everything reads 0 while reset is held.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pc_lat_n  = pc_lat;
    exc_type  = 32'h0;
    inst_addr = 32'h0;
    in_ds     = 1'b0;
    flush     = 1'b0;
    busy      = 1'b0;
    new_pc    = 32'h0;
    case (state)
      IDLE: begin
        exc_type  = sel;
        inst_addr = bus.mem_inst_addr_i;
        in_ds     = bus.mem_is_in_delayslot_i;
        if (sel != 32'h0) begin
          flush  = 1'b1;
          new_pc = (sel == CODE_ERET) ? epc : EXC_VECTOR;
          if (FLUSH_CYCLES > 1) begin
            state_n  = FLUSH;
            cnt_n    = 4'(FLUSH_CYCLES - 1);
            pc_lat_n = new_pc;
          end
        end
      end
      FLUSH: begin
        // New flags here belong to the squashed instruction: drop them.
        flush  = 1'b1;
        busy   = 1'b1;
        new_pc = pc_lat;
        cnt_n  = cnt - 4'd1;
        if (cnt == 4'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      exc_type  = 32'h0;
      inst_addr = 32'h0;
      in_ds     = 1'b0;
      flush     = 1'b0;
      busy      = 1'b0;
      new_pc    = 32'h0;
    end
  end

  assign bus.excepttype_o        = exc_type;
  assign bus.current_inst_addr_o = inst_addr;
  assign bus.is_in_delayslot_o   = in_ds;
  assign bus.flush_o             = flush;
  assign bus.new_pc_o            = new_pc;
  assign bus.busy_o              = busy;

`ifdef EXC_STATS_EN
  // Count exceptions taken from IDLE; eret is a return, not an exception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exc_count_o <= 32'h0;
    else if (state == IDLE && sel != 32'h0 && sel != CODE_ERET) exc_count_o <= exc_count_o + 32'h1;
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.mem_excepttype_i[31:13], bus.mem_excepttype_i[7:0],
                         status[31:16], status[7:2], cause[31:16], cause[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a vector table for the combinational select
// and bypass paths, plus hand-written multi-cycle flush/reset sequences.
module tb_exc_ctrl;
  logic clk, rst;
  int tests, fails;

  exc_ctrl_if bus();

`ifdef EXC_STATS_EN
  logic [31:0] exc_count;
  exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .exc_count_o(exc_count));
`else
  exc_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exc;
    logic [31:0] addr;
    logic        ds;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_type;
    logic        exp_flush;
    logic [31:0] exp_newpc;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.mem_excepttype_i      = 32'h0;
    bus.mem_inst_addr_i       = 32'h0;
    bus.mem_is_in_delayslot_i = 1'b0;
    bus.cp0_status_i          = 32'h0;
    bus.cp0_cause_i           = 32'h0;
    bus.cp0_epc_i             = 32'h0;
    bus.wb_cp0_reg_we_i       = 1'b0;
    bus.wb_cp0_reg_waddr_i    = 5'd0;
    bus.wb_cp0_reg_data_i     = 32'h0;
  endtask

  task automatic syscall(input logic [31:0] pc);
    clr();
    bus.mem_excepttype_i = 32'h100;
    bus.mem_inst_addr_i  = pc;
  endtask

  // Bubble inputs long enough for any flush window to drain.
  task automatic gap();
    @(negedge clk); clr();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    tests = 0; fails = 0;
    //            exc      addr          ds    status        cause         epc      we    wa     wdata    type   fl    newpc
    vecs[0]  = '{32'h0,    32'h100,      1'b0, 32'h0,        32'h0,        32'h0,   1'b0, 5'd0,  32'h0,   32'h0, 1'b0, 32'h0};
    vecs[1]  = '{32'h100,  32'h100,      1'b0, 32'h0,        32'h0,        32'h0,   1'b0, 5'd0,  32'h0,   32'h8, 1'b1, 32'h20};
    vecs[2]  = '{32'h1D00, 32'h104,      1'b1, 32'h0,        32'h0,        32'h0,   1'b0, 5'd0,  32'h0,   32'h8, 1'b1, 32'h20};
    vecs[3]  = '{32'h1E00, 32'h108,      1'b0, 32'h0,        32'h0,        32'h0,   1'b0, 5'd0,  32'h0,   32'ha, 1'b1, 32'h20};
    vecs[4]  = '{32'h1C00, 32'h10c,      1'b0, 32'h0,        32'h0,        32'h0,   1'b0, 5'd0,  32'h0,   32'hd, 1'b1, 32'h20};
    vecs[5]  = '{32'h1800, 32'h110,      1'b1, 32'h0,        32'h0,        32'h0,   1'b0, 5'd0,  32'h0,   32'hc, 1'b1, 32'h20};
    vecs[6]  = '{32'h1000, 32'h200,      1'b0, 32'h0,        32'h0,        32'h40,  1'b0, 5'd0,  32'h0,   32'he, 1'b1, 32'h40};
    vecs[7]  = '{32'h1000, 32'h200,      1'b0, 32'h0,        32'h0,        32'h40,  1'b1, 5'd14, 32'h80,  32'he, 1'b1, 32'h80};
    vecs[8]  = '{32'h100,  32'h300,      1'b0, 32'h401,      32'h400,      32'h0,   1'b0, 5'd0,  32'h0,   32'h1, 1'b1, 32'h20};
    vecs[9]  = '{32'h100,  32'h0,        1'b0, 32'h401,      32'h400,      32'h0,   1'b0, 5'd0,  32'h0,   32'h0, 1'b0, 32'h0};
    vecs[10] = '{32'h0,    32'h304,      1'b0, 32'h403,      32'h400,      32'h0,   1'b0, 5'd0,  32'h0,   32'h0, 1'b0, 32'h0};
    vecs[11] = '{32'h0,    32'h308,      1'b0, 32'h0,        32'h400,      32'h0,   1'b1, 5'd12, 32'h401, 32'h1, 1'b1, 32'h20};
    vecs[12] = '{32'h0,    32'h30c,      1'b0, 32'h101,      32'h0,        32'h0,   1'b1, 5'd13, 32'h100, 32'h1, 1'b1, 32'h20};
    vecs[13] = '{32'h1000, 32'h310,      1'b0, 32'h400,      32'h400,      32'h44,  1'b0, 5'd0,  32'h0,   32'he, 1'b1, 32'h44};
    vecs[14] = '{32'h100,  32'h80000000, 1'b1, 32'h0,        32'h0,        32'h0,   1'b0, 5'd0,  32'h0,   32'h8, 1'b1, 32'h20};

    // Reset state: outputs stay 0 even with a syscall presented.
    clr(); rst = 1'b1;
    syscall(32'h100);
    @(negedge clk); #1;
    chk("rst_type",  bus.excepttype_o, 32'h0);
    chk("rst_flush", {31'h0, bus.flush_o}, 32'h0);
    chk("rst_busy",  {31'h0, bus.busy_o}, 32'h0);
    chk("rst_addr",  bus.current_inst_addr_o, 32'h0);
    @(negedge clk); clr(); rst = 1'b0;
    @(negedge clk);

    // Combinational select / bypass vectors.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.mem_excepttype_i      = vecs[i].exc;
      bus.mem_inst_addr_i       = vecs[i].addr;
      bus.mem_is_in_delayslot_i = vecs[i].ds;
      bus.cp0_status_i          = vecs[i].status;
      bus.cp0_cause_i           = vecs[i].cause;
      bus.cp0_epc_i             = vecs[i].epc;
      bus.wb_cp0_reg_we_i       = vecs[i].we;
      bus.wb_cp0_reg_waddr_i    = vecs[i].waddr;
      bus.wb_cp0_reg_data_i     = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_type", i),  bus.excepttype_o, vecs[i].exp_type);
      chk($sformatf("v%0d_flush", i), {31'h0, bus.flush_o}, {31'h0, vecs[i].exp_flush});
      chk($sformatf("v%0d_busy", i),  {31'h0, bus.busy_o}, 32'h0);
      chk($sformatf("v%0d_addr", i),  bus.current_inst_addr_o, vecs[i].addr);
      chk($sformatf("v%0d_ds", i),    {31'h0, bus.is_in_delayslot_o}, {31'h0, vecs[i].ds});
      if (vecs[i].exp_flush) chk($sformatf("v%0d_newpc", i), bus.new_pc_o, vecs[i].exp_newpc);
      gap();
    end

    // Flush window: 2 cycles, busy only in the second, new flags ignored.
    @(negedge clk); syscall(32'h100); #1;
    chk("seqA_c1_type",  bus.excepttype_o, 32'h8);
    chk("seqA_c1_flush", {31'h0, bus.flush_o}, 32'h1);
    chk("seqA_c1_busy",  {31'h0, bus.busy_o}, 32'h0);
    @(negedge clk); syscall(32'h104); #1;
    chk("seqA_c2_type",  bus.excepttype_o, 32'h0);
    chk("seqA_c2_addr",  bus.current_inst_addr_o, 32'h0);
    chk("seqA_c2_flush", {31'h0, bus.flush_o}, 32'h1);
    chk("seqA_c2_busy",  {31'h0, bus.busy_o}, 32'h1);
    chk("seqA_c2_newpc", bus.new_pc_o, 32'h20);
    @(negedge clk); clr(); #1;
    chk("seqA_c3_flush", {31'h0, bus.flush_o}, 32'h0);
    chk("seqA_c3_busy",  {31'h0, bus.busy_o}, 32'h0);
    gap();

    // Back-to-back: exception in first IDLE cycle after FLUSH is taken.
    @(negedge clk); syscall(32'h100);
    @(negedge clk); clr();
    @(negedge clk); syscall(32'h108); #1;
    chk("seqB_type",  bus.excepttype_o, 32'h8);
    chk("seqB_flush", {31'h0, bus.flush_o}, 32'h1);
    chk("seqB_busy",  {31'h0, bus.busy_o}, 32'h0);
    @(negedge clk); clr(); #1;
    chk("seqB_fl_busy", {31'h0, bus.busy_o}, 32'h1);
    gap();

    // eret target latched at detection survives EPC changes during FLUSH.
    @(negedge clk); clr();
    bus.mem_excepttype_i = 32'h1000; bus.mem_inst_addr_i = 32'h200;
    bus.cp0_epc_i = 32'h40; bus.wb_cp0_reg_we_i = 1'b1;
    bus.wb_cp0_reg_waddr_i = 5'd14; bus.wb_cp0_reg_data_i = 32'h80; #1;
    chk("seqC_newpc", bus.new_pc_o, 32'h80);
    @(negedge clk); clr(); bus.cp0_epc_i = 32'h40; #1;
    chk("seqC_fl_newpc", bus.new_pc_o, 32'h80);
    gap();

    // Reset mid-FLUSH: flush drops at once, next syscall accepted.
    @(negedge clk); syscall(32'h100);
    @(negedge clk); rst = 1'b1; #1;
    chk("seqD_rst_flush", {31'h0, bus.flush_o}, 32'h0);
    chk("seqD_rst_busy",  {31'h0, bus.busy_o}, 32'h0);
    chk("seqD_rst_newpc", bus.new_pc_o, 32'h0);
    @(negedge clk); clr(); rst = 1'b0; #1;
    chk("seqD_idle_busy", {31'h0, bus.busy_o}, 32'h0);
    @(negedge clk); syscall(32'h100); #1;
    chk("seqD_type",  bus.excepttype_o, 32'h8);
    chk("seqD_flush", {31'h0, bus.flush_o}, 32'h1);
    chk("seqD_busy",  {31'h0, bus.busy_o}, 32'h0);
`ifdef EXC_STATS_EN
    @(posedge clk); #1;
    chk("seqD_count", exc_count, 32'h1);
`endif
    gap();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
